wb_slave_port_arbiter: RTL

//  Per-slave-port arbiter for the NxN Wishbone interconnect: one instance per slave port.

---
 rtl/wb_ic_pkg.sv | 16 +
 rtl/wb_rr_pick.sv | 31 +++
 rtl/wb_slave_port_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/wb_ic_pkg.sv
// Shared types and helpers for the Wishbone NxN interconnect blocks.
package wb_ic_pkg;

  // Arbiter states for one slave port.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWNED = 2'd1,
    ARB_ABORT = 2'd2
  } wb_arb_state_e;

  // Width of a master index; a single master still gets a 1-bit index.
  function automatic int mid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping mod N.
// Rotate so ptr lands at bit 0, priority-encode the lowest set bit, then
// add ptr back (mod N) to recover the original master index.
module wb_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          found
);

  logic [N-1:0] rot;
  logic [PW:0]  off;
  logic [PW:0]  sum;

  // Rotate, priority-encode, un-rotate.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    found = |rot;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = (PW + 1)'(i);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (PW + 1)'(N)) sum = sum - (PW + 1)'(N);
    idx = sum[PW-1:0];
  end

endmodule

// File: rtl/wb_slave_port_arbiter.sv
// Per-slave-port arbiter: round-robin grant locked for a whole CYC tenure,
// plus a watchdog that errors out and kills a tenure whose slave stalls.
//
// Request/grant contract: a master requests by holding req (which implies
// cyc). The grant appears one edge after the pick and is held, ignoring all
// other requests, until the owner drops cyc; the grant then clears on the
// next edge and at least one idle cycle separates tenures. All outputs are
// registered.
module wb_slave_port_arbiter
  import wb_ic_pkg::*;
#(
  parameter int N_MASTERS      = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int MID_W         = mid_width(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] cyc,
  input  logic [N_MASTERS-1:0] stb,
  input  logic                 ack,
  input  logic                 err,
  output logic [N_MASTERS-1:0] gnt,
  output logic [MID_W-1:0]     gnt_id,
  output logic                 gnt_valid,
  output logic                 to_err,
  output logic                 slave_kill,
  output wb_arb_state_e        arb_state
);

  // A zero timeout disables the watchdog; keep the counter at least 1 bit.
  localparam int               CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit               WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  wb_arb_state_e        state_q, state_d;
  logic [MID_W-1:0]     ptr_q, ptr_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [MID_W-1:0]     gnt_id_q, gnt_id_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic                 to_err_q, to_err_d;
  logic                 slave_kill_q, slave_kill_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [MID_W-1:0]     pick_idx;
  logic                 pick_found;
  logic                 owner_cyc;
  logic                 stalled;
  logic [MID_W-1:0]     next_ptr;

  wb_rr_pick #(
    .N  (N_MASTERS),
    .PW (MID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Owner-side view of the bus and the pointer that follows the owner.
  always_comb begin
    owner_cyc = cyc[gnt_id_q];
    stalled   = stb[gnt_id_q] & ~ack & ~err;
    if (gnt_id_q == MID_W'(N_MASTERS - 1)) next_ptr = '0;
    else                                   next_ptr = gnt_id_q + MID_W'(1);
  end

  // Next-state logic for the arbiter FSM, grant registers and watchdog.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    gnt_valid_d  = gnt_valid_q;
    to_err_d     = 1'b0;
    slave_kill_d = slave_kill_q;
    cnt_d        = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        cnt_d        = '0;
        slave_kill_d = 1'b0;
        if (pick_found) begin
          state_d         = ARB_OWNED;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          gnt_id_d        = pick_idx;
          gnt_valid_d     = 1'b1;
        end
      end
      ARB_OWNED: begin
        if (!owner_cyc) begin
          // Release beats a watchdog expiry on the same edge.
          state_d     = ARB_IDLE;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          cnt_d       = '0;
          ptr_d       = next_ptr;
        end else if (WDOG_EN && stalled && (cnt_q == LIMIT)) begin
          // Limit reached with the beat still stalled (no ack/err this cycle).
          state_d      = ARB_ABORT;
          to_err_d     = 1'b1;
          slave_kill_d = 1'b1;
          cnt_d        = '0;
        end else if (WDOG_EN && stalled) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ARB_ABORT: begin
        // Slave ack/err is ignored here; wait for the owner to give up.
        cnt_d = '0;
        if (!owner_cyc) begin
          state_d      = ARB_IDLE;
          gnt_d        = '0;
          gnt_id_d     = '0;
          gnt_valid_d  = 1'b0;
          slave_kill_d = 1'b0;
          ptr_d        = next_ptr;
        end
      end
      default: begin
        state_d      = ARB_IDLE;
        gnt_d        = '0;
        gnt_id_d     = '0;
        gnt_valid_d  = 1'b0;
        slave_kill_d = 1'b0;
        cnt_d        = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      gnt_valid_q  <= 1'b0;
      to_err_q     <= 1'b0;
      slave_kill_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      gnt_valid_q  <= gnt_valid_d;
      to_err_q     <= to_err_d;
      slave_kill_q <= slave_kill_d;
      cnt_q        <= cnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign gnt_id     = gnt_id_q;
  assign gnt_valid  = gnt_valid_q;
  assign to_err     = to_err_q;
  assign slave_kill = slave_kill_q;
  assign arb_state  = state_q;

  // A master may only request this slave while its CYC is high.
  a_req_implies_cyc: assert property (@(posedge clk) disable iff (rst) ((req & ~cyc) == '0));

endmodule
